// File: rtl/alu_flag_capture.sv
// rtl/alu_flag_capture.sv - ALU result/carry capture with Z/N/C/V flag accumulation (optional STICKY_V_EN)
module alu_flag_capture #(
    parameter int N         = 4,
    parameter int CHAIN_MAX = 4
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [N-1:0]                     RESULT,
    input  logic                             CARRY_OUT,
    input  logic                             OP_A_MSB,
    input  logic                             OP_B_MSB,
    input  logic                             OP_SUB,
    input  logic                             CHAIN,
    input  logic                             CLEAR,
    output logic                             CARRY_FB,
    output logic                             FLAGS_VALID,
    output logic                             FLAG_Z,
    output logic                             FLAG_N,
    output logic                             FLAG_C,
    output logic                             FLAG_V,
    output logic                             CHAIN_ERR,
    output logic [$clog2(CHAIN_MAX+1)-1:0]   WORD_CNT
);

    localparam int CW = $clog2(CHAIN_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          zacc_q, zacc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fb_q, fb_d;
    logic          fv_q, fv_d;
    logic          z_q, z_d;
    logic          n_q, n_d;
    logic          c_q, c_d;
    logic          v_q, v_d;
    logic          err_q, err_d;

    logic accept;
    logic word_zero;
    logic ovf;
    logic finalize;

    assign IN_READY  = RST_N & ~CLEAR;
    assign accept    = IN_VALID & IN_READY;
    assign word_zero = (RESULT == '0);
    assign ovf       = (OP_A_MSB ~^ (OP_B_MSB ^ OP_SUB)) & (OP_A_MSB ^ RESULT[N-1]);

    // Next-state: start/extend an operation on accept, publish flags on its last word
    always_comb begin
        state_d  = state_q;
        zacc_d   = zacc_q;
        cnt_d    = cnt_q;
        fb_d     = fb_q;
        fv_d     = fv_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        err_d    = err_q;
        finalize = 1'b0;
        if (accept) begin
            if (state_q == ST_CHAIN) begin
                zacc_d = zacc_q & word_zero;
                cnt_d  = cnt_q + 1'b1;
            end else begin
                zacc_d = word_zero;
                cnt_d  = CW'(1);
                fv_d   = 1'b0;
                err_d  = 1'b0;
            end
            // Force-terminate a chain that hits the word limit while still asking for more
            finalize = ~CHAIN | (cnt_d == CW'(CHAIN_MAX));
            if (finalize) begin
                state_d = ST_DONE;
                z_d     = zacc_d;
                n_d     = RESULT[N-1];
                c_d     = CARRY_OUT;
`ifdef STICKY_V_EN
                v_d     = v_q | ovf;
`else
                v_d     = ovf;
`endif
                err_d   = CHAIN;
                fv_d    = 1'b1;
                // A fresh operation takes its carry-in from the op select, not feedback
                fb_d    = 1'b0;
            end else begin
                state_d = ST_CHAIN;
                fb_d    = CARRY_OUT;
            end
        end
    end

    // State registers; reset and CLEAR both discard any partial operation
    always_ff @(posedge CLK) begin
        if (!RST_N || CLEAR) begin
            state_q <= ST_IDLE;
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
            fb_q    <= 1'b0;
            fv_q    <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zacc_q  <= zacc_d;
            cnt_q   <= cnt_d;
            fb_q    <= fb_d;
            fv_q    <= fv_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    assign CARRY_FB    = fb_q;
    assign FLAGS_VALID = fv_q;
    assign FLAG_Z      = z_q;
    assign FLAG_N      = n_q;
    assign FLAG_C      = c_q;
    assign FLAG_V      = v_q;
    assign CHAIN_ERR   = err_q;
    assign WORD_CNT    = cnt_q;

endmodule

// File: tb/tb_alu_flag_capture.sv
// tb/tb_alu_flag_capture.sv - self-checking bench for alu_flag_capture
module tb_alu_flag_capture;

    localparam int N         = 4;
    localparam int CHAIN_MAX = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] RESULT = 4'd0;
    logic       CARRY_OUT = 1'b0;
    logic       OP_A_MSB = 1'b0;
    logic       OP_B_MSB = 1'b0;
    logic       OP_SUB = 1'b0;
    logic       CHAIN = 1'b0;
    logic       CLEAR = 1'b0;
    logic       CARRY_FB, FLAGS_VALID, FLAG_Z, FLAG_N, FLAG_C, FLAG_V, CHAIN_ERR;
    logic [2:0] WORD_CNT;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // model state: results of the operation in progress, plus expected outputs
    logic [3:0] op_words[$];
    bit         in_op = 1'b0;
    logic       e_fv = 0, e_z = 0, e_n = 0, e_c = 0, e_v = 0, e_err = 0, e_fb = 0;
    logic [2:0] e_cnt = 0;

    alu_flag_capture #(.N(N), .CHAIN_MAX(CHAIN_MAX)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .RESULT(RESULT), .CARRY_OUT(CARRY_OUT), .OP_A_MSB(OP_A_MSB),
        .OP_B_MSB(OP_B_MSB), .OP_SUB(OP_SUB), .CHAIN(CHAIN), .CLEAR(CLEAR),
        .CARRY_FB(CARRY_FB), .FLAGS_VALID(FLAGS_VALID), .FLAG_Z(FLAG_Z),
        .FLAG_N(FLAG_N), .FLAG_C(FLAG_C), .FLAG_V(FLAG_V),
        .CHAIN_ERR(CHAIN_ERR), .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // spec-level model: apply one clock edge with the currently driven inputs
    task automatic model_edge();
        logic bsign, ovf, allz;
        if (!RST_N || CLEAR) begin
            op_words.delete();
            in_op = 0;
            {e_fv, e_z, e_n, e_c, e_v, e_err, e_fb} = '0;
            e_cnt = 0;
        end else if (IN_VALID) begin
            if (!in_op) begin
                op_words.delete();
                e_fv  = 0;
                e_err = 0;
            end
            op_words.push_back(RESULT);
            e_cnt = 3'(op_words.size());
            if (!CHAIN || op_words.size() == CHAIN_MAX) begin
                allz = 1'b1;
                foreach (op_words[i]) if (op_words[i] != 4'd0) allz = 1'b0;
                // signed overflow: effective operand signs agree, result sign differs
                bsign = OP_SUB ? ~OP_B_MSB : OP_B_MSB;
                ovf   = (OP_A_MSB == bsign) && (RESULT[3] != OP_A_MSB);
                e_z   = allz;
                e_n   = RESULT[3];
                e_c   = CARRY_OUT;
`ifdef STICKY_V_EN
                e_v   = e_v | ovf;
`else
                e_v   = ovf;
`endif
                e_err = CHAIN;
                e_fv  = 1;
                e_fb  = 0;
                in_op = 0;
            end else begin
                e_fb  = CARRY_OUT;
                in_op = 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [3:0] r, input logic co,
                        input logic a, input logic b, input logic s,
                        input logic ch, input logic cl, input logic rn);
        IN_VALID = v; RESULT = r; CARRY_OUT = co; OP_A_MSB = a; OP_B_MSB = b;
        OP_SUB = s; CHAIN = ch; CLEAR = cl; RST_N = rn;
        @(posedge CLK);
        model_edge();
        #2;
    endtask

    task automatic idle();
        step(0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // compare every output against the model once per cycle, away from the edge
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk1("in_ready",    IN_READY,    RST_N & ~CLEAR);
            chk1("flags_valid", FLAGS_VALID, e_fv);
            chk1("flag_z",      FLAG_Z,      e_z);
            chk1("flag_n",      FLAG_N,      e_n);
            chk1("flag_c",      FLAG_C,      e_c);
            chk1("flag_v",      FLAG_V,      e_v);
            chk1("chain_err",   CHAIN_ERR,   e_err);
            chk1("carry_fb",    CARRY_FB,    e_fb);
            chkc("word_cnt",    WORD_CNT,    e_cnt);
        end
    end

    initial begin
        step(0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        chk1("rst_fv", FLAGS_VALID, 1'b0);
        chkc("rst_cnt", WORD_CNT, 3'd0);
        chk1("rst_fb", CARRY_FB, 1'b0);
        idle();

        // 1: single zero word with carry
        step(1, 4'b0000, 1, 0, 0, 0, 0, 0, 1);
        chk1("t1_fv", FLAGS_VALID, 1'b1);
        chk1("t1_z", FLAG_Z, 1'b1);
        chk1("t1_n", FLAG_N, 1'b0);
        chk1("t1_c", FLAG_C, 1'b1);
        chk1("t1_v", FLAG_V, 1'b0);
        chkc("t1_cnt", WORD_CNT, 3'd1);
        chk1("t1_fb", CARRY_FB, 1'b0);
        idle();

        // 2: add overflow, then a clean op
        step(1, 4'b1000, 0, 0, 0, 0, 0, 0, 1);
        chk1("t2_v", FLAG_V, 1'b1);
        chk1("t2_n", FLAG_N, 1'b1);
        chk1("t2_z", FLAG_Z, 1'b0);
        step(1, 4'b0001, 0, 0, 0, 0, 0, 0, 1);
`ifdef STICKY_V_EN
        chk1("t2_v_next", FLAG_V, 1'b1);
`else
        chk1("t2_v_next", FLAG_V, 1'b0);
`endif
        // subtract overflow: neg - pos giving positive
        step(1, 4'b0111, 1, 1, 0, 1, 0, 0, 1);
        chk1("t2_vsub", FLAG_V, 1'b1);

        // 3: two-word chain
        step(1, 4'b0000, 1, 0, 0, 0, 1, 0, 1);
        chk1("t3_fb", CARRY_FB, 1'b1);
        chk1("t3_fv", FLAGS_VALID, 1'b0);
        step(1, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
        chk1("t3_z", FLAG_Z, 1'b1);
        chk1("t3_c", FLAG_C, 1'b0);
        chk1("t3_fb2", CARRY_FB, 1'b0);
        chkc("t3_cnt", WORD_CNT, 3'd2);

        // 4: zero accumulation across idle gap
        step(1, 4'b0000, 1, 0, 0, 0, 1, 0, 1);
        idle();
        idle();
        chk1("t4_fb_hold", CARRY_FB, 1'b1);
        chkc("t4_cnt_hold", WORD_CNT, 3'd1);
        step(1, 4'b0100, 0, 0, 0, 0, 0, 0, 1);
        chk1("t4_z", FLAG_Z, 1'b0);
        chkc("t4_cnt", WORD_CNT, 3'd2);

        // 5: chain limit
        for (int i = 0; i < CHAIN_MAX; i++) step(1, 4'(i), i[0], 0, 0, 0, 1, 0, 1);
        chk1("t5_err", CHAIN_ERR, 1'b1);
        chk1("t5_fv", FLAGS_VALID, 1'b1);
        chkc("t5_cnt", WORD_CNT, 3'd4);
        chk1("t5_z", FLAG_Z, 1'b0);
        step(1, 4'b0010, 0, 0, 0, 0, 0, 0, 1);
        chkc("t5_cnt_new", WORD_CNT, 3'd1);
        chk1("t5_err_new", CHAIN_ERR, 1'b0);

        // 6: CLEAR with a word mid-chain, then reset mid-chain
        step(1, 4'b0011, 1, 0, 0, 0, 1, 0, 1);
        step(1, 4'b0101, 1, 0, 0, 0, 1, 1, 1);
        chk1("t6_fb", CARRY_FB, 1'b0);
        chk1("t6_fv", FLAGS_VALID, 1'b0);
        chkc("t6_cnt", WORD_CNT, 3'd0);
        step(1, 4'b0011, 1, 0, 0, 0, 1, 0, 1);
        step(1, 4'b0101, 1, 0, 0, 0, 0, 0, 0);
        chk1("t6r_fb", CARRY_FB, 1'b0);
        chk1("t6r_fv", FLAGS_VALID, 1'b0);
        chkc("t6r_cnt", WORD_CNT, 3'd0);
        idle();
        step(1, 4'b1111, 1, 1, 1, 0, 0, 0, 1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_flag_capture.md
Name: alu_flag_capture

Overview:
- Registered consumer side of the ALU carry path. Accepts each ALU result word and carry-out over a valid/ready handshake.
- Accumulates the status flags Z, N, C and V across single-word or chained multi-word operations.
- Drives CARRY_FB back to the SEL input of the ALU carry-in select, so word k+1 of a chained add/sub uses the carry-out of word k.
- Sits between the ALU datapath and the display/control logic.

Parameters:
N, 4, ALU word width in bits (>=2)
CHAIN_MAX, 4, maximum words per chained operation (>=2)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  synchronous reset, active-low
IN_VALID  input  1  ALU word present this cycle
IN_READY  output  1  block can accept a word this cycle
RESULT  input  N  ALU result word
CARRY_OUT  input  1  ALU carry-out for RESULT
OP_A_MSB  input  1  MSB of operand A (overflow calc)
OP_B_MSB  input  1  MSB of operand B (overflow calc)
OP_SUB  input  1  1 = subtract operation
CHAIN  input  1  1 = more words follow; 0 = last word of operation
CLEAR  input  1  abort/clear all state
CARRY_FB  output  1  stored carry for next chained word; drives carry-in select
FLAGS_VALID  output  1  flags below describe a completed operation
FLAG_Z  output  1  every word of the operation was zero
FLAG_N  output  1  RESULT[N-1] of the last word
FLAG_C  output  1  CARRY_OUT of the last word
FLAG_V  output  1  signed overflow of the last word
CHAIN_ERR  output  1  operation was force-terminated at CHAIN_MAX words
WORD_CNT  output  clog2(CHAIN_MAX+1)  words accepted in the current operation

Behaviour:
- Interface: synchronous reset, active-low (RST_N sampled on rising CLK; reset is synchronous and active-low). One clock, CLK.
- Reset, or CLEAR=1:
  - State=IDLE.
  - All flags, FLAGS_VALID, CHAIN_ERR, CARRY_FB, WORD_CNT = 0.
  - Internal zero accumulator = 1.
- IN_READY = RST_N & ~CLEAR (combinational). A word is accepted when IN_VALID & IN_READY.
- CLEAR has priority over an accept in the same cycle; that word is dropped.
- States: IDLE, CHAINING, DONE.
  - IDLE or DONE + accept:
    - Start a new operation: zero accumulator reloads as (RESULT==0), WORD_CNT=1, FLAGS_VALID=0, CHAIN_ERR=0.
    - If CHAIN=1: go to CHAINING, CARRY_FB=CARRY_OUT.
    - If CHAIN=0: finalize (below) and go to DONE.
  - CHAINING + accept:
    - zacc &= (RESULT==0); WORD_CNT+1; CARRY_FB=CARRY_OUT.
    - If CHAIN=0: finalize, go to DONE.
    - If CHAIN=1 and the new WORD_CNT == CHAIN_MAX: finalize with CHAIN_ERR=1, go to DONE.
  - CHAINING, no accept: hold everything; CARRY_FB stable.
- Finalize, registered on the accepting edge:
  - FLAG_Z = zacc including the current word.
  - FLAG_N = RESULT[N-1].
  - FLAG_C = CARRY_OUT.
  - FLAG_V = (OP_A_MSB ~^ (OP_B_MSB ^ OP_SUB)) & (OP_A_MSB ^ RESULT[N-1]).
  - FLAGS_VALID=1.
  - CARRY_FB=0, because a new operation takes carry-in from op select, not feedback.
- Latency: flags are visible 1 cycle after the accepting edge of the last word.
- DONE holds the flags and FLAGS_VALID=1 until the next accept or CLEAR. WORD_CNT holds its final value.
- Intermediate words never update FLAG_N/C/V. Their carry is visible only on CARRY_FB.
- Reset asserted mid-chain: partial operation discarded, no flags published.

Optional Feature:
STICKY_V_EN
- Defined: FLAG_V becomes sticky. It is set by any finalized operation with overflow and cleared only by reset or CLEAR; it is not cleared at the start of a new operation.
- Undefined: FLAG_V reflects the most recent finalized operation only.

Test Plan:
1. N=4, single word: RESULT=0000, CARRY_OUT=1, CHAIN=0, OP_SUB=0, A_MSB=0, B_MSB=0 -> next cycle FLAGS_VALID=1, Z=1, N=0, C=1, V=0, WORD_CNT=1, CARRY_FB=0.
2. Signed overflow: A_MSB=0, B_MSB=0, OP_SUB=0, RESULT=1000, CHAIN=0 -> V=1, N=1, Z=0. Next op RESULT=0001 with no overflow -> V=0 without macro, V=1 with STICKY_V_EN.
3. Two-word chain: word1 RESULT=0000, CARRY_OUT=1, CHAIN=1 -> CARRY_FB=1, FLAGS_VALID=0. Word2 RESULT=0000, CARRY_OUT=0, CHAIN=0 -> Z=1, C=0, CARRY_FB=0, WORD_CNT=2.
4. Zero accumulation: chain RESULT=0000 then 0100 (CHAIN 1,0) -> Z=0. Two idle cycles between the words -> CARRY_FB held, result unchanged.
5. CHAIN_MAX=4: four words all with CHAIN=1 -> after the 4th, CHAIN_ERR=1, FLAGS_VALID=1, state DONE. The 5th word starts a new operation with WORD_CNT=1 and CHAIN_ERR=0.
6. CLEAR and IN_VALID together in CHAINING -> IN_READY=0, word dropped, all outputs 0 next cycle. RST_N=0 for one edge mid-chain -> same result.
